// File: rtl/ip_pack_receiver.sv
// Receive side of an IP node: reassembles flits from the switch local port, checks address/length, counts packets.
// Optional define RECV_STALL_EN adds LFSR-driven pseudo-random backpressure on r_ready_out.
module ip_pack_receiver #(
  parameter int DATA_SIZE    = 8,
  parameter int ADDR_SIZE    = 4,
  parameter int ADDR         = 0,
  parameter int MAX_PACK_LEN = 4
) (
  input  logic                         clk,
  input  logic                         a_rst,
  input  logic [DATA_SIZE+ADDR_SIZE:0] data_i,
  input  logic                         wr_ready_in,
  output logic                         r_ready_out,
  output logic [31:0]                  recv_packs,
  output logic [31:0]                  err_packs,
  output logic [15:0]                  last_len,
  output logic [DATA_SIZE-1:0]         last_sum,
  output logic                         pack_valid
);

  localparam int FLIT_SIZE = DATA_SIZE + ADDR_SIZE + 1;
  localparam logic [ADDR_SIZE-1:0] ADDR_BITS = ADDR_SIZE'(ADDR);
  localparam logic [15:0] MAX_LEN = 16'(MAX_PACK_LEN);

  typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

  state_t               state, state_next;
  logic [15:0]          len, len_next, len_inc;
  logic [DATA_SIZE-1:0] sum, sum_next;
  logic                 addr_ok, addr_ok_next;
  logic                 done_good, done_bad;
  logic                 xfer, flit_tail, addr_match;
  logic [DATA_SIZE-1:0] payload;

  assign flit_tail  = data_i[FLIT_SIZE-1];
  assign addr_match = (data_i[FLIT_SIZE-2:DATA_SIZE] == ADDR_BITS);
  assign payload    = data_i[DATA_SIZE-1:0];
  assign xfer       = wr_ready_in & r_ready_out;
  assign len_inc    = (len == 16'hFFFF) ? len : len + 16'd1;

  // Next-state and completion decode; a single-flit packet completes straight out of IDLE.
  always_comb begin
    state_next   = state;
    len_next     = len;
    sum_next     = sum;
    addr_ok_next = addr_ok;
    done_good    = 1'b0;
    done_bad     = 1'b0;
    if (xfer) begin
      case (state)
        IDLE: begin
          addr_ok_next = addr_match;
          len_next     = 16'd1;
          sum_next     = payload;
          if (flit_tail) begin
            done_good = addr_match;
            done_bad  = ~addr_match;
          end else begin
            state_next = RECV;
          end
        end
        RECV: begin
          len_next = len_inc;
          sum_next = sum + payload;
          if (flit_tail) begin
            done_good  = addr_ok & (len_inc <= MAX_LEN);
            done_bad   = ~(addr_ok & (len_inc <= MAX_LEN));
            state_next = IDLE;
          end else if (len_inc > MAX_LEN) begin
            state_next = DROP;
          end
        end
        DROP: begin
          if (flit_tail) begin
            done_bad   = 1'b1;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      state   <= IDLE;
      len     <= '0;
      sum     <= '0;
      addr_ok <= 1'b0;
    end else begin
      state   <= state_next;
      len     <= len_next;
      sum     <= sum_next;
      addr_ok <= addr_ok_next;
    end
  end

  // Counters saturate rather than wrap so long soak runs never read as small values.
  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      recv_packs <= '0;
      err_packs  <= '0;
      last_len   <= '0;
      last_sum   <= '0;
      pack_valid <= 1'b0;
    end else begin
      pack_valid <= done_good;
      if (done_good) begin
        last_len <= len_next;
        last_sum <= sum_next;
        if (recv_packs != 32'hFFFF_FFFF) recv_packs <= recv_packs + 32'd1;
      end
      if (done_bad && err_packs != 32'hFFFF_FFFF) err_packs <= err_packs + 32'd1;
    end
  end

`ifdef RECV_STALL_EN
  localparam logic [15:0] LFSR_SEED = 16'({ADDR_BITS, 1'b1});
  logic [15:0] lfsr;
  logic        lfsr_fb;

  // Fibonacci taps 16,14,13,11; seed depends on ADDR so each node stalls differently.
  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      lfsr        <= LFSR_SEED;
      r_ready_out <= 1'b0;
    end else begin
      lfsr        <= {lfsr[14:0], lfsr_fb};
      r_ready_out <= (lfsr[1:0] != 2'b00);
    end
  end
`else
  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) r_ready_out <= 1'b0;
    else        r_ready_out <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_ip_pack_receiver.sv
// Self-checking bench for ip_pack_receiver: packet-level queue model compared every cycle, plus literal checks.
module tb_ip_pack_receiver;

  localparam int ADDR    = 3;
  localparam int MAX_LEN = 4;
  localparam int FW      = 13;

  typedef logic [FW-1:0] flit_t;
  typedef flit_t flitq_t[$];

  logic        clk = 1'b0;
  logic        a_rst = 1'b0;
  flit_t       data_i = '0;
  logic        wr_ready_in = 1'b0;
  logic        r_ready_out;
  logic [31:0] recv_packs, err_packs;
  logic [15:0] last_len;
  logic [7:0]  last_sum;
  logic        pack_valid;

  int n_compared = 0;
  int n_mismatched = 0;

  ip_pack_receiver #(.DATA_SIZE(8), .ADDR_SIZE(4), .ADDR(ADDR), .MAX_PACK_LEN(MAX_LEN)) dut (
    .clk(clk), .a_rst(a_rst), .data_i(data_i), .wr_ready_in(wr_ready_in),
    .r_ready_out(r_ready_out), .recv_packs(recv_packs), .err_packs(err_packs),
    .last_len(last_len), .last_sum(last_sum), .pack_valid(pack_valid)
  );

  always #5 clk = ~clk;

  function automatic flit_t mk_flit(input logic tail, input logic [3:0] addr, input logic [7:0] pay);
    return {tail, addr, pay};
  endfunction

  // Packet-level judgement: head address must match and total flits must fit.
  function automatic logic pkt_good(input flitq_t q, input flit_t last);
    flit_t head = (q.size() == 0) ? last : q[0];
    return (head[11:8] == 4'(ADDR)) && (q.size() + 1 <= MAX_LEN);
  endfunction

  function automatic logic [7:0] pkt_sum(input flitq_t q, input flit_t last);
    logic [7:0] s = last[7:0];
    foreach (q[i]) s = s + q[i][7:0];
    return s;
  endfunction

  flitq_t      pkt_q;
  logic [31:0] exp_recv = '0, exp_err = '0;
  logic [15:0] exp_len = '0;
  logic [7:0]  exp_sum = '0;
  logic        exp_pv = 1'b0, exp_rdy = 1'b0;
  int          xfer_cnt = 0;

  // Model: collect accepted flits per packet, judge the whole packet on its tail.
  always @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      pkt_q.delete();
      exp_recv <= '0; exp_err <= '0; exp_len <= '0; exp_sum <= '0;
      exp_pv <= 1'b0; exp_rdy <= 1'b0; xfer_cnt <= 0;
    end else begin
      exp_rdy <= 1'b1;
      exp_pv  <= 1'b0;
      if (wr_ready_in && r_ready_out) begin
        xfer_cnt <= xfer_cnt + 1;
        if (data_i[FW-1]) begin
          if (pkt_good(pkt_q, data_i)) begin
            exp_recv <= (exp_recv == 32'hFFFF_FFFF) ? exp_recv : exp_recv + 1;
            exp_len  <= 16'(pkt_q.size() + 1);
            exp_sum  <= pkt_sum(pkt_q, data_i);
            exp_pv   <= 1'b1;
          end else begin
            exp_err <= (exp_err == 32'hFFFF_FFFF) ? exp_err : exp_err + 1;
          end
          pkt_q.delete();
        end else begin
          pkt_q.push_back(data_i);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("recv_packs", recv_packs, exp_recv);
    checkOutput("err_packs", err_packs, exp_err);
    checkOutput("last_len", 32'(last_len), 32'(exp_len));
    checkOutput("last_sum", 32'(last_sum), 32'(exp_sum));
    checkOutput("pack_valid", 32'(pack_valid), 32'(exp_pv));
`ifndef RECV_STALL_EN
    checkOutput("r_ready_out", 32'(r_ready_out), 32'(exp_rdy));
`endif
  end

  logic t6_active = 1'b0;
  int   rdy_hi = 0, rdy_lo = 0;
  always @(negedge clk) begin
    if (t6_active) begin
      if (r_ready_out) rdy_hi <= rdy_hi + 1;
      else             rdy_lo <= rdy_lo + 1;
    end
  end

  // Present one flit and hold it until the posedge on which it is accepted.
  task automatic applyStimulus(input flit_t f);
    int waits = 0;
    @(negedge clk);
    data_i = f;
    wr_ready_in = 1'b1;
    while (!r_ready_out && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    if (!r_ready_out) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL accept_timeout: got r_ready_out=0 for %0d cycles, expected 1", waits);
    end
  endtask

  task automatic idleIn();
    @(negedge clk);
    wr_ready_in = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk);
    #1 a_rst = 1'b0;
    wr_ready_in = 1'b0;
    repeat (2) @(negedge clk);
    #1 a_rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] test 1: reset with wr_ready_in held high");
    wr_ready_in = 1'b1;
    data_i = mk_flit(1'b1, 4'd3, 8'h55);
    repeat (3) @(negedge clk);
    checkOutput("t1_recv", recv_packs, 32'd0);
    checkOutput("t1_err", err_packs, 32'd0);
    checkOutput("t1_pv", 32'(pack_valid), 32'd0);
    checkOutput("t1_rdy_in_reset", 32'(r_ready_out), 32'd0);
    #1 a_rst = 1'b1;
    wr_ready_in = 1'b0;
    @(negedge clk);
`ifndef RECV_STALL_EN
    checkOutput("t1_rdy_after", 32'(r_ready_out), 32'd1);
`endif
    checkOutput("t1_recv_after", recv_packs, 32'd0);

    $display("[TB] test 2: good 3-flit packet");
    applyStimulus(mk_flit(1'b0, 4'd3, 8'h10));
    applyStimulus(mk_flit(1'b0, 4'd3, 8'h20));
    applyStimulus(mk_flit(1'b1, 4'd3, 8'hF5));
    idleIn();
    checkOutput("t2_recv", recv_packs, 32'd1);
    checkOutput("t2_len", 32'(last_len), 32'd3);
    checkOutput("t2_sum", 32'(last_sum), 32'h25);
    checkOutput("t2_pv_hi", 32'(pack_valid), 32'd1);
    checkOutput("t2_model_sum", 32'(exp_sum), 32'h25);
    @(negedge clk);
    checkOutput("t2_pv_lo", 32'(pack_valid), 32'd0);

    $display("[TB] test 3: wrong address single flit");
    doReset();
    applyStimulus(mk_flit(1'b1, 4'd5, 8'h77));
    idleIn();
    checkOutput("t3_err", err_packs, 32'd1);
    checkOutput("t3_recv", recv_packs, 32'd0);
    checkOutput("t3_pv", 32'(pack_valid), 32'd0);

    $display("[TB] test 4: overlength packet then good single flit");
    doReset();
    for (int i = 1; i <= 6; i++) applyStimulus(mk_flit(i == 6, 4'd3, 8'(i)));
    idleIn();
    checkOutput("t4_err", err_packs, 32'd1);
    checkOutput("t4_recv_mid", recv_packs, 32'd0);
    checkOutput("t4_xfers", 32'(xfer_cnt), 32'd6);
    applyStimulus(mk_flit(1'b1, 4'd3, 8'h42));
    idleIn();
    checkOutput("t4_recv", recv_packs, 32'd1);
    checkOutput("t4_len", 32'(last_len), 32'd1);
    checkOutput("t4_sum", 32'(last_sum), 32'h42);

    $display("[TB] test 5: reset mid-packet");
    doReset();
    applyStimulus(mk_flit(1'b0, 4'd3, 8'hAA));
    applyStimulus(mk_flit(1'b0, 4'd3, 8'hBB));
    doReset();
    checkOutput("t5_recv_rst", recv_packs, 32'd0);
    applyStimulus(mk_flit(1'b0, 4'd3, 8'h01));
    applyStimulus(mk_flit(1'b1, 4'd3, 8'h02));
    idleIn();
    checkOutput("t5_recv", recv_packs, 32'd1);
    checkOutput("t5_len", 32'(last_len), 32'd2);
    checkOutput("t5_sum", 32'(last_sum), 32'h03);
    checkOutput("t5_err", err_packs, 32'd0);

    $display("[TB] test 6: 20 back-to-back 2-flit packets");
    doReset();
    t6_active = 1'b1;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(mk_flit(1'b0, 4'd3, 8'(k)));
      applyStimulus(mk_flit(1'b1, 4'd3, 8'(k + 1)));
    end
    idleIn();
    t6_active = 1'b0;
    checkOutput("t6_recv", recv_packs, 32'd20);
    checkOutput("t6_err", err_packs, 32'd0);
    checkOutput("t6_len", 32'(last_len), 32'd2);
    checkOutput("t6_sum", 32'(last_sum), 32'h27);
    checkOutput("t6_xfers", 32'(xfer_cnt), 32'd40);
`ifdef RECV_STALL_EN
    checkOutput("t6_rdy_low_seen", 32'(rdy_lo != 0), 32'd1);
    checkOutput("t6_rdy_high_seen", 32'(rdy_hi != 0), 32'd1);
`else
    checkOutput("t6_rdy_never_low", 32'(rdy_lo), 32'd0);
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
